param_lifo: RTL
===============

# param_lifo

Parametrised synchronous LIFO stack: next generation of the team's 16x16 stack, generalised in data width and depth. Adds simultaneous push+pop (replace-top / pass-through), a combinational peek of the top entry, occupancy count, almost-full threshold, synchronous flush and sticky overflow/underflow error flags. Sits between a producer and consumer in the datapath as a last-in-first-out scratch buffer.

## Interface
- WIDTH, 16, data word width in bits (>= 1)
- DEPTH, 16, number of entries (>= 2)
- AF_LEVEL, DEPTH-2, almostFull asserts when count >= AF_LEVEL (1..DEPTH)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- EN  in  1  operation enable; when 0, push/pop/flush ignored
- push  in  1  write dataIn onto stack
- pop  in  1  read top entry into dataOut
- flush  in  1  discard all entries
- clrErr  in  1  clear sticky error flags
- dataIn  in  WIDTH  push data
- dataOut  out  WIDTH  last popped word, registered
- dataValid  out  1  one-cycle pulse: dataOut updated this cycle
- top  out  WIDTH  combinational peek of top entry; 0 when empty
- count  out  CW  number of stored entries
- EMPTY  out  1  count == 0
- FULL  out  1  count == DEPTH
- almostFull  out  1  count >= AF_LEVEL
- overflow  out  1  sticky: push rejected while full
- underflow  out  1  sticky: pop rejected while empty

## Operation
- Storage: mem[0..DEPTH-1]; entry count-1 is top. Memory not cleared by reset or flush.
- Reset (Rst=1 at edge, overrides all inputs incl. EN): count=0, dataOut=0, dataValid=0, overflow=0, underflow=0. Hence EMPTY=1, FULL=0, almostFull=(AF_LEVEL==0 ? 1 : 0) → effectively 0, top=0.
- EN=0: state held, dataValid=0, no errors raised; clrErr still honoured.
- Priority when EN=1: flush > push&pop > push > pop.
- flush: count<=0; push/pop that cycle ignored, no errors, dataValid=0.
- push only, !FULL: mem[count]<=dataIn, count+1. FULL: data dropped, count held, overflow<=1.
- pop only, !EMPTY: dataOut<=mem[count-1], dataValid<=1, count-1. EMPTY: dataOut held, dataValid=0, underflow<=1.
- push&pop, !EMPTY (incl. FULL): replace top: dataOut<=mem[count-1], mem[count-1]<=dataIn, dataValid<=1, count unchanged, no errors.
- push&pop, EMPTY: pass-through: dataOut<=dataIn, dataValid<=1, count stays 0, no errors.
- clrErr: clears both sticky flags; an error event in the same cycle wins (flag ends 1).
- dataOut holds its value between pops; dataValid high exactly one cycle per accepted pop.
- Count arithmetic in CW bits; never exceeds DEPTH, never wraps below 0.

## Timing
- All outputs except top are registered; they reflect the operation one rising edge after it is presented.
- EMPTY/FULL/almostFull decode from registered count: valid in the cycle after the push/pop edge; the blocking decision for the current cycle uses current count.
- Pop latency: 1 cycle (pop at edge N → dataOut/dataValid valid after edge N).
- top combinational from mem and count: after a push at edge N, top==pushed data after edge N.
- Back-to-back push or pop every cycle sustained at full rate; no bubbles.
- Rst asserted mid-operation: pending op discarded at that edge; stack empty next cycle.

## Test plan
- Reset, then push 1..DEPTH (WIDTH=16, DEPTH=16) → count=16, FULL=1, almostFull from count 14, top=16; pop 16 times → dataOut 16,15,…,1 each with dataValid pulse, EMPTY=1 at end.
- Full stack, push 0xAAAA → overflow=1, count=16, top unchanged; clrErr → overflow=0; clrErr with same-cycle overflowing push → overflow=1.
- Empty stack, pop → underflow=1, dataValid=0, dataOut held; push&pop 0x1234 → dataOut=0x1234, dataValid=1, count=0.
- Stack holding 5,6,7; push&pop 9 → dataOut=7, top=9, count=3; repeat at FULL → count stays 16, no overflow.
- EN=0 with push/pop toggling → count, dataOut, flags unchanged, dataValid=0; flush with push=1 at count=8 → count=0, EMPTY=1, top=0.
- Rst=1 at a cycle with push=1 at count=3 → count=0, errors 0, dataOut=0; DEPTH=5, WIDTH=8, AF_LEVEL=4 regression of scenario 1.

Source files
------------

// File: rtl/param_lifo.sv
// -----------------------------------------------------------------------------
// param_lifo -- parametrised synchronous LIFO stack
//
// Last-in-first-out scratch buffer between a producer and a consumer. It
// supports simultaneous push+pop, which either replaces the top entry or
// passes the data straight through when the stack is empty. It also provides:
//   - a combinational peek of the top entry
//   - an occupancy count and an almost-full threshold
//   - a synchronous flush
//   - sticky overflow/underflow error flags
//
// Parameters
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of entries (>= 2)
//   AF_LEVEL  almostFull asserts when count >= AF_LEVEL (1..DEPTH)
//   CW        count width, derived from DEPTH (not meant to be overridden)
//
// Ports
//   Clk        clock; all logic runs on the rising edge
//   Rst        synchronous active-high reset; overrides every other input
//   EN         operation enable; push/pop/flush are ignored when low
//   push       write dataIn onto the stack
//   pop        read the top entry into dataOut
//   flush      discard all entries
//   clrErr     clear the sticky error flags
//   dataIn     push data
//   dataOut    last popped word (registered, held between pops)
//   dataValid  one-cycle pulse: dataOut was updated this cycle
//   top        combinational peek of the top entry; 0 when empty
//   count      number of stored entries
//   EMPTY      count == 0
//   FULL       count == DEPTH
//   almostFull count >= AF_LEVEL
//   overflow   sticky: a push was rejected while full
//   underflow  sticky: a pop was rejected while empty
// -----------------------------------------------------------------------------
module param_lifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             EN,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             clrErr,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             EMPTY,
  output logic             FULL,
  output logic             almostFull,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] data_out_reg, data_out_next;
  logic             data_valid_reg, data_valid_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic             empty, full;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] top_word;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic             do_flush, do_pp, do_push, do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  // When empty this address is meaningless; every use is gated by 'empty'.
  assign top_addr = AW'(count_reg - 1'b1);
  assign top_word = mem[top_addr];

  // Decode the operation for this cycle: flush > push&pop > push > pop.
  assign do_flush = EN & flush;
  assign do_pp    = EN & ~flush & push & pop;
  assign do_push  = EN & ~flush & push & ~pop;
  assign do_pop   = EN & ~flush & pop & ~push;

  always_comb begin
    count_next      = count_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    // clrErr is honoured regardless of EN; an error raised below overrides it.
    overflow_next   = overflow_reg & ~clrErr;
    underflow_next  = underflow_reg & ~clrErr;
    mem_we          = 1'b0;
    mem_waddr       = AW'(count_reg);

    if (do_flush) begin
      count_next = '0;
    end else if (do_pp) begin
      data_valid_next = 1'b1;
      if (empty) begin
        // Nothing stored: the pushed word goes straight to the consumer.
        data_out_next = dataIn;
      end else begin
        // Replace top: the old top leaves, the new word takes its slot.
        data_out_next = top_word;
        mem_we        = 1'b1;
        mem_waddr     = top_addr;
      end
    end else if (do_push) begin
      if (full) begin
        overflow_next = 1'b1;
      end else begin
        mem_we     = 1'b1;
        count_next = count_reg + 1'b1;
      end
    end else if (do_pop) begin
      if (empty) begin
        underflow_next = 1'b1;
      end else begin
        data_out_next   = top_word;
        data_valid_next = 1'b1;
        count_next      = count_reg - 1'b1;
      end
    end
  end

  // Storage is never cleared; only count decides which entries are live.
  always_ff @(posedge Clk) begin
    if (mem_we && !Rst) begin
      mem[mem_waddr] <= dataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      count_reg      <= count_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      overflow_reg   <= overflow_next;
      underflow_reg  <= underflow_next;
    end
  end

  assign dataOut    = data_out_reg;
  assign dataValid  = data_valid_reg;
  assign count      = count_reg;
  assign EMPTY      = empty;
  assign FULL       = full;
  assign almostFull = (count_reg >= CW'(AF_LEVEL));
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;
  assign top        = empty ? '0 : top_word;

endmodule
